// File: rtl/projectile_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// projectile_scheduler_pkg
// Shared game constants and types: arena bounds, projectile speed and
// lifetime, owner encoding, plus the per-axis move/bounce helper. The battle
// screen renderer and player motion logic import the same package, so the
// arena geometry is defined here and only here.
// ---------------------------------------------------------------------------
package projectile_scheduler_pkg;

    localparam int COORD_W    = 10;
    localparam int ARENA_X_MIN = 364;
    localparam int ARENA_X_MAX = 563;
    localparam int ARENA_Y_MIN = 221;
    localparam int ARENA_Y_MAX = 320;
    localparam int BASE_STEP  = 12;
    localparam int LIFE_TICKS = 16;

    typedef enum logic {
        OWNER_PLAYER = 1'b0,
        OWNER_ENEMY  = 1'b1
    } owner_e;

    // Everything a slot needs at launch time. dir = {xdir, ydir},
    // 0 = increasing, 1 = decreasing.
    typedef struct packed {
        logic               owner;
        logic [1:0]         dir;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } launch_t;

    typedef struct packed {
        logic               dir;
        logic [COORD_W-1:0] pos;
    } axis_t;

    function automatic logic [COORD_W-1:0] clamp(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // One axis step in 10-bit unsigned arithmetic. Reaching or passing the
    // bound in the travel direction pins the coordinate to that bound and
    // reverses direction, so the next step moves back into the arena.
    function automatic axis_t axis_move(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        axis_t              r;
        logic [COORD_W-1:0] fwd;
        logic [COORD_W-1:0] bwd;
        fwd   = pos + step;
        bwd   = pos - step;
        r.dir = dir;
        r.pos = pos;
        if (!dir) begin
            if (fwd >= hi) begin
                r.pos = hi;
                r.dir = 1'b1;
            end else begin
                r.pos = fwd;
            end
        end else begin
            if (bwd <= lo) begin
                r.pos = lo;
                r.dir = 1'b0;
            end else begin
                r.pos = bwd;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/projectile_scheduler_proj_slot.sv
// ---------------------------------------------------------------------------
// proj_slot
// State of one projectile slot: occupancy, owner, direction, position and
// remaining life. Handles load, move/bounce on tick, and aging.
// Priority: clear > load > tick, so a freshly loaded slot neither moves nor
// ages in its load cycle.
// Ports:
//   clk, rst          clock, async active-high reset
//   clear             flush (drops valid)
//   load, launch      write a new projectile (launch already clamped)
//   tick, step        move strobe and per-tick distance
//   valid, owner, x, y registered slot state
//   valid_nxt         next-state valid, for the top-level full register
// ---------------------------------------------------------------------------
module proj_slot
    import projectile_scheduler_pkg::*;
#(
    parameter int X_MIN = ARENA_X_MIN,
    parameter int X_MAX = ARENA_X_MAX,
    parameter int Y_MIN = ARENA_Y_MIN,
    parameter int Y_MAX = ARENA_Y_MAX,
    parameter int LIFE  = LIFE_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  launch_t            launch,
    input  logic               tick,
    input  logic [COORD_W-1:0] step,
    output logic               valid,
    output logic               valid_nxt,
    output logic               owner,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam int LW = $clog2(LIFE + 1);
    localparam logic [COORD_W-1:0] XLO = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XHI = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YLO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YHI = COORD_W'(Y_MAX);

    logic               xdir, ydir;
    logic [LW-1:0]      life;

    logic               owner_nxt, xdir_nxt, ydir_nxt;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic [LW-1:0]      life_nxt;
    axis_t              mx, my;

    always_comb begin
        mx = axis_move(x, xdir, step, XLO, XHI);
        my = axis_move(y, ydir, step, YLO, YHI);
    end

    always_comb begin
        valid_nxt = valid;
        owner_nxt = owner;
        xdir_nxt  = xdir;
        ydir_nxt  = ydir;
        x_nxt     = x;
        y_nxt     = y;
        life_nxt  = life;
        if (clear) begin
            valid_nxt = 1'b0;
        end else if (load) begin
            valid_nxt = 1'b1;
            owner_nxt = launch.owner;
            xdir_nxt  = launch.dir[1];
            ydir_nxt  = launch.dir[0];
            x_nxt     = launch.x;
            y_nxt     = launch.y;
            life_nxt  = LW'(LIFE);
        end else if (tick && valid) begin
            x_nxt    = mx.pos;
            xdir_nxt = mx.dir;
            y_nxt    = my.pos;
            ydir_nxt = my.dir;
            life_nxt = life - LW'(1);
            // last tick of life frees the slot in the same update
            if (life == LW'(1)) valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            owner <= 1'b0;
            xdir  <= 1'b0;
            ydir  <= 1'b0;
            x     <= '0;
            y     <= '0;
            life  <= '0;
        end else begin
            valid <= valid_nxt;
            owner <= owner_nxt;
            xdir  <= xdir_nxt;
            ydir  <= ydir_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            life  <= life_nxt;
        end
    end

endmodule

// File: rtl/projectile_scheduler.sv
// ---------------------------------------------------------------------------
// projectile_scheduler
// Allocates player/enemy fire requests into NSLOT projectile slots and moves
// live projectiles on each tick. Contains the free-slot priority encoder, the
// player/enemy arbiter with a 1-bit round-robin pointer, and the ack/full
// registers; per-slot state lives in proj_slot.
// Ports:
//   clk, rst                 clock, async active-high reset
//   tick, clear, level       move strobe, flush, difficulty (step = BASE+level)
//   p_req/e_req, *_x/_y/_dir fire requests with launch position/direction
//   p_ack/e_ack              one-cycle grant pulses
//   slot_valid/owner/x/y     registered slot state, x/y flattened 10 bits each
//   full                     all slots occupied
// ---------------------------------------------------------------------------
module projectile_scheduler
    import projectile_scheduler_pkg::*;
#(
    parameter int NSLOT     = 4,
    parameter int X_MIN     = ARENA_X_MIN,
    parameter int X_MAX     = ARENA_X_MAX,
    parameter int Y_MIN     = ARENA_Y_MIN,
    parameter int Y_MAX     = ARENA_Y_MAX,
    parameter int BASE_STEP = projectile_scheduler_pkg::BASE_STEP,
    parameter int LIFE      = LIFE_TICKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     clear,
    input  logic [2:0]               level,
    input  logic                     p_req,
    input  logic                     e_req,
    input  logic [COORD_W-1:0]       p_x,
    input  logic [COORD_W-1:0]       p_y,
    input  logic [COORD_W-1:0]       e_x,
    input  logic [COORD_W-1:0]       e_y,
    input  logic [1:0]               p_dir,
    input  logic [1:0]               e_dir,
    output logic                     p_ack,
    output logic                     e_ack,
    output logic [NSLOT-1:0]         slot_valid,
    output logic [NSLOT-1:0]         slot_owner,
    output logic [COORD_W*NSLOT-1:0] slot_x,
    output logic [COORD_W*NSLOT-1:0] slot_y,
    output logic                     full
);

    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [COORD_W-1:0] XLO = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XHI = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YLO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] YHI = COORD_W'(Y_MAX);

    logic [COORD_W-1:0] step;
    launch_t            p_launch, e_launch;
    logic               elig_p, elig_e;
    logic               has0, has1;
    logic [IW-1:0]      idx0, idx1;
    logic               gp, ge;
    logic [IW-1:0]      ip, ie;
    logic               rr, rr_nxt;
    logic [NSLOT-1:0]   valid_nxt;

    assign step = COORD_W'(BASE_STEP) + {{(COORD_W-3){1'b0}}, level};

    always_comb begin
        p_launch.owner = OWNER_PLAYER;
        p_launch.dir   = p_dir;
        p_launch.x     = clamp(p_x, XLO, XHI);
        p_launch.y     = clamp(p_y, YLO, YHI);
        e_launch.owner = OWNER_ENEMY;
        e_launch.dir   = e_dir;
        e_launch.x     = clamp(e_x, XLO, XHI);
        e_launch.y     = clamp(e_y, YLO, YHI);
    end

    // A requester whose ack is showing was just served; its req may still be
    // high for this cycle, so it sits out one sample.
    assign elig_p = p_req && !p_ack;
    assign elig_e = e_req && !e_ack;

    // Lowest and second-lowest free slot. Freedom is judged on registered
    // valid, so a slot expiring on this tick is not reused until next cycle.
    always_comb begin
        has0 = 1'b0;
        has1 = 1'b0;
        idx0 = '0;
        idx1 = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!slot_valid[i]) begin
                if (!has0) begin
                    has0 = 1'b1;
                    idx0 = IW'(i);
                end else if (!has1) begin
                    has1 = 1'b1;
                    idx1 = IW'(i);
                end
            end
        end
    end

    // Arbiter: two free slots serve both at once (player low, enemy next);
    // a single free slot under contention goes to the round-robin pick.
    always_comb begin
        gp     = 1'b0;
        ge     = 1'b0;
        ip     = idx0;
        ie     = idx0;
        rr_nxt = rr;
        if (!clear) begin
            if (elig_p && elig_e) begin
                if (has1) begin
                    gp = 1'b1;
                    ge = 1'b1;
                    ie = idx1;
                end else if (has0) begin
                    if (rr == OWNER_PLAYER) gp = 1'b1;
                    else                    ge = 1'b1;
                    rr_nxt = ~rr;
                end
            end else if (elig_p && has0) begin
                gp = 1'b1;
            end else if (elig_e && has0) begin
                ge = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        logic    load;
        launch_t launch;
        assign load   = (gp && ip == IW'(i)) || (ge && ie == IW'(i));
        assign launch = (ge && ie == IW'(i)) ? e_launch : p_launch;

        proj_slot #(
            .X_MIN (X_MIN),
            .X_MAX (X_MAX),
            .Y_MIN (Y_MIN),
            .Y_MAX (Y_MAX),
            .LIFE  (LIFE)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .load      (load),
            .launch    (launch),
            .tick      (tick),
            .step      (step),
            .valid     (slot_valid[i]),
            .valid_nxt (valid_nxt[i]),
            .owner     (slot_owner[i]),
            .x         (slot_x[COORD_W*i +: COORD_W]),
            .y         (slot_y[COORD_W*i +: COORD_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ack <= 1'b0;
            e_ack <= 1'b0;
            full  <= 1'b0;
            rr    <= OWNER_PLAYER;
        end else begin
            p_ack <= gp;
            e_ack <= ge;
            full  <= &valid_nxt;
            rr    <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_projectile_scheduler.sv
module tb_projectile_scheduler;

    logic        clk = 1'b0;
    logic        rst, tick, clear;
    logic [2:0]  level;
    logic        p_req, e_req;
    logic [9:0]  p_x, p_y, e_x, e_y;
    logic [1:0]  p_dir, e_dir;
    logic        p_ack, e_ack;
    logic [3:0]  slot_valid, slot_owner;
    logic [39:0] slot_x, slot_y;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    projectile_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .clear(clear), .level(level),
        .p_req(p_req), .e_req(e_req),
        .p_x(p_x), .p_y(p_y), .e_x(e_x), .e_y(e_y),
        .p_dir(p_dir), .e_dir(e_dir),
        .p_ack(p_ack), .e_ack(e_ack),
        .slot_valid(slot_valid), .slot_owner(slot_owner),
        .slot_x(slot_x), .slot_y(slot_y), .full(full)
    );

    function automatic logic [9:0] sx(input int i);
        return slot_x[10*i +: 10];
    endfunction
    function automatic logic [9:0] sy(input int i);
        return slot_y[10*i +: 10];
    endfunction

    // advance one edge; inputs changed afterwards are well clear of it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic clear_all();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (slot_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", slot_valid); end
        n_checks++;
        if ({p_ack, e_ack, full} !== 3'b000) begin n_fail++; $display("FAIL reset_ack_full: got %b expected 000", {p_ack, e_ack, full}); end
        n_checks++;
        if (slot_x !== 40'd0 || slot_owner !== 4'b0) begin n_fail++; $display("FAIL reset_state: got x=%h own=%b expected 0", slot_x, slot_owner); end
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_player_fire();
        p_req = 1'b1; p_x = 10'd400; p_y = 10'd250; p_dir = 2'b00;
        cyc();
        p_req = 1'b0;
        n_checks++;
        if (p_ack !== 1'b1 || e_ack !== 1'b0) begin n_fail++; $display("FAIL fire_ack: got p=%b e=%b expected p=1 e=0", p_ack, e_ack); end
        n_checks++;
        if (slot_valid !== 4'b0001 || slot_owner[0] !== 1'b0) begin n_fail++; $display("FAIL fire_slot: got v=%b own=%b expected v=0001 own0=0", slot_valid, slot_owner); end
        n_checks++;
        if (sx(0) !== 10'd400 || sy(0) !== 10'd250) begin n_fail++; $display("FAIL fire_pos: got (%0d,%0d) expected (400,250)", sx(0), sy(0)); end
        cyc();
        n_checks++;
        if (p_ack !== 1'b0) begin n_fail++; $display("FAIL fire_ack_pulse: got %b expected 0", p_ack); end
        do_tick();
        n_checks++;
        if (sx(0) !== 10'd412 || sy(0) !== 10'd262) begin n_fail++; $display("FAIL fire_move: got (%0d,%0d) expected (412,262)", sx(0), sy(0)); end
        clear_all();
    endtask

    task automatic test_bounce();
        level = 3'd3;
        p_req = 1'b1; p_x = 10'd560; p_y = 10'd310; p_dir = 2'b00;
        cyc();
        p_req = 1'b0;
        n_checks++;
        if (sx(0) !== 10'd560 || sy(0) !== 10'd310) begin n_fail++; $display("FAIL bounce_load: got (%0d,%0d) expected (560,310)", sx(0), sy(0)); end
        do_tick();
        n_checks++;
        if (sx(0) !== 10'd563 || sy(0) !== 10'd320) begin n_fail++; $display("FAIL bounce_sat: got (%0d,%0d) expected (563,320)", sx(0), sy(0)); end
        do_tick();
        n_checks++;
        if (sx(0) !== 10'd548 || sy(0) !== 10'd305) begin n_fail++; $display("FAIL bounce_back: got (%0d,%0d) expected (548,305)", sx(0), sy(0)); end
        level = 3'd0;
        clear_all();
    endtask

    task automatic test_saturation();
        p_req = 1'b1; p_x = 10'd100; p_y = 10'd500; p_dir = 2'b11;
        cyc();
        p_req = 1'b0;
        n_checks++;
        if (sx(0) !== 10'd364 || sy(0) !== 10'd320) begin n_fail++; $display("FAIL sat_load: got (%0d,%0d) expected (364,320)", sx(0), sy(0)); end
        cyc();
        clear_all();
    endtask

    task automatic test_clear();
        e_x = 10'd450; e_y = 10'd230; e_dir = 2'b01;
        p_req = 1'b1; e_req = 1'b1;
        cyc();
        p_req = 1'b0; e_req = 1'b0;
        n_checks++;
        if ({p_ack, e_ack} !== 2'b11 || slot_valid !== 4'b0011 || slot_owner[1:0] !== 2'b10) begin
            n_fail++; $display("FAIL dual_grant: got ack=%b v=%b own=%b expected ack=11 v=0011 own=10", {p_ack, e_ack}, slot_valid, slot_owner);
        end
        cyc();
        p_req = 1'b1; e_req = 1'b1;
        cyc();
        p_req = 1'b0; e_req = 1'b0;
        n_checks++;
        if (slot_valid !== 4'b1111 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got v=%b full=%b expected 1111 1", slot_valid, full); end
        cyc();
        e_req = 1'b1; clear = 1'b1;
        cyc();
        clear = 1'b0;
        n_checks++;
        if (slot_valid !== 4'b0000 || e_ack !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL clear_flush: got v=%b e_ack=%b full=%b expected 0000 0 0", slot_valid, e_ack, full); end
        cyc();
        e_req = 1'b0;
        n_checks++;
        if (e_ack !== 1'b1 || slot_valid !== 4'b0001 || slot_owner[0] !== 1'b1) begin n_fail++; $display("FAIL clear_then_grant: got e_ack=%b v=%b own=%b expected 1 0001 own0=1", e_ack, slot_valid, slot_owner); end
        cyc();
        clear_all();
    endtask

    task automatic fill_three();
        p_req = 1'b1; e_req = 1'b1;
        cyc();
        p_req = 1'b0; e_req = 1'b0;
        cyc();
        p_req = 1'b1;
        cyc();
        p_req = 1'b0;
        cyc();
    endtask

    task automatic test_contention();
        fill_three();
        n_checks++;
        if (slot_valid !== 4'b0111) begin n_fail++; $display("FAIL cont_fill: got %b expected 0111", slot_valid); end
        do_tick();
        do_tick();
        p_req = 1'b1; e_req = 1'b1;
        cyc();
        p_req = 1'b0;
        n_checks++;
        if ({p_ack, e_ack} !== 2'b10 || slot_owner[3] !== 1'b0 || full !== 1'b1) begin
            n_fail++; $display("FAIL cont_player_first: got ack=%b own3=%b full=%b expected 10 0 1", {p_ack, e_ack}, slot_owner[3], full);
        end
        cyc();
        n_checks++;
        if (e_ack !== 1'b0) begin n_fail++; $display("FAIL cont_no_slot: got e_ack=%b expected 0", e_ack); end
        for (int k = 0; k < 14; k++) do_tick();
        n_checks++;
        if (slot_valid !== 4'b1000 || e_ack !== 1'b0) begin n_fail++; $display("FAIL cont_expire: got v=%b e_ack=%b expected 1000 0", slot_valid, e_ack); end
        cyc();
        e_req = 1'b0;
        n_checks++;
        if (e_ack !== 1'b1 || slot_valid !== 4'b1001 || slot_owner[0] !== 1'b1) begin n_fail++; $display("FAIL cont_pending_served: got e_ack=%b v=%b own=%b expected 1 1001 own0=1", e_ack, slot_valid, slot_owner); end
        cyc();
        clear_all();
        // pointer moved to the enemy after the contested grant above
        fill_three();
        p_req = 1'b1; e_req = 1'b1;
        cyc();
        e_req = 1'b0;
        n_checks++;
        if ({p_ack, e_ack} !== 2'b01 || slot_owner[3] !== 1'b1) begin n_fail++; $display("FAIL cont_rr_enemy: got ack=%b own3=%b expected 01 1", {p_ack, e_ack}, slot_owner[3]); end
        cyc();
        p_req = 1'b0;
        clear_all();
    endtask

    task automatic test_lifetime();
        p_req = 1'b1; p_x = 10'd400; p_y = 10'd250; p_dir = 2'b00;
        cyc();
        p_req = 1'b0;
        cyc();
        for (int k = 0; k < 15; k++) do_tick();
        n_checks++;
        if (slot_valid !== 4'b0001) begin n_fail++; $display("FAIL life_15: got %b expected 0001", slot_valid); end
        tick = 1'b1; p_req = 1'b1;
        cyc();
        tick = 1'b0; p_req = 1'b0;
        n_checks++;
        if (slot_valid !== 4'b0010 || p_ack !== 1'b1) begin n_fail++; $display("FAIL life_16_regrant: got v=%b p_ack=%b expected 0010 1", slot_valid, p_ack); end
        cyc();
    endtask

    task automatic test_async_reset();
        p_req = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (p_ack !== 1'b0 || slot_valid !== 4'b0000 || full !== 1'b0) begin n_fail++; $display("FAIL async_rst: got p_ack=%b v=%b full=%b expected 0 0000 0", p_ack, slot_valid, full); end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (p_ack !== 1'b0) begin n_fail++; $display("FAIL rst_release: got p_ack=%b expected 0", p_ack); end
        cyc();
        p_req = 1'b0;
        n_checks++;
        if (p_ack !== 1'b1 || slot_valid !== 4'b0001) begin n_fail++; $display("FAIL rst_fresh_grant: got p_ack=%b v=%b expected 1 0001", p_ack, slot_valid); end
        cyc();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; clear = 1'b0; level = 3'd0;
        p_req = 1'b0; e_req = 1'b0;
        p_x = '0; p_y = '0; e_x = '0; e_y = '0; p_dir = '0; e_dir = '0;
        test_reset();
        cyc();
        test_player_fire();
        test_bounce();
        test_saturation();
        test_clear();
        test_contention();
        test_lifetime();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/projectile_scheduler.md
PROJECTILE_SCHEDULER -- requirements
Module: projectile_scheduler

Interface
REQ-001 Parameter NSLOT, default 4: number of projectile slots.
REQ-002 Parameters X_MIN/X_MAX, default 364/563; Y_MIN/Y_MAX, default 221/320: inclusive arena bounds.
REQ-003 Parameter BASE_STEP, default 12: pixels moved per tick at level 0.
REQ-004 Parameter LIFE, default 16: ticks a projectile lives.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 tick  in  1  one-cycle move strobe, synchronous to clk.
REQ-008 clear  in  1  synchronous flush of all slots.
REQ-009 level  in  3  difficulty; step = BASE_STEP + level.
REQ-010 p_req, e_req  in  1 each  player/enemy fire request, level-held until ack.
REQ-011 p_x/p_y, e_x/e_y  in  10 each  launch position.
REQ-012 p_dir, e_dir  in  2 each  {xdir, ydir}; 0 = increasing, 1 = decreasing.
REQ-013 p_ack, e_ack  out  1 each  one-cycle grant pulse.
REQ-014 slot_valid  out  NSLOT  slot occupied.
REQ-015 slot_owner  out  NSLOT  0 = player, 1 = enemy.
REQ-016 slot_x, slot_y  out  10*NSLOT each  flattened positions; slot i at [10i+9:10i].
REQ-017 full  out  1  all slots valid.

Function
REQ-018 All outputs shall be registered.
REQ-019 Requests shall be sampled on the rising edge; a requester is eligible only if its req=1 and its ack is currently 0.
REQ-020 A grant shall load the lowest-index free slot: valid=1, owner, direction, life=LIFE, and position clamped to the arena bounds.
REQ-021 The corresponding ack shall be high exactly in the cycle after the sampling edge; the slot shall show valid in the same cycle.
REQ-022 With one free slot and both eligible, a 1-bit round-robin pointer (reset: player first) shall pick the winner; the pointer toggles after each contested grant.
REQ-023 With two or more free slots and both eligible, both shall be granted in the same cycle: player to the lowest free slot, enemy to the next.
REQ-024 With no free slot, no ack shall be issued; req remains pending with no loss.
REQ-025 On tick, each valid slot shall move x and y by step in its direction, using 10-bit unsigned arithmetic.
REQ-026 On a move, if the new coordinate is at or beyond the bound in the travel direction, it shall saturate to that bound and the direction bit shall invert (bounce).
REQ-027 On tick, life shall decrement; a slot whose life reaches 0 on this tick shall clear valid in the same update.
REQ-028 A slot loaded in the same cycle as tick shall not move or age that cycle; a slot freed by tick shall not be reallocated that cycle.
REQ-029 clear shall invalidate all slots and suppress grants and acks that cycle; it has priority over tick and requests.
REQ-030 full shall equal the AND of slot_valid as registered.

Reset
REQ-031 On rst, all slots shall be invalid; positions, owners, directions and life shall be 0; p_ack=e_ack=0; full=0; round-robin pointer = player.
REQ-032 rst mid-operation shall abort any pending grant; no ack shall appear after release until a fresh sample.

Structure
REQ-033 Arena bounds, BASE_STEP, LIFE and owner encoding shall live in the shared game package, also used by the battle screen renderer and player motion logic.
REQ-034 A sub-module proj_slot shall hold one slot's state and implement load, move/bounce and aging; the top level shall contain the free-slot priority encoder, arbiter and ack registers.

Verification
REQ-035 Player fire: p_req at (400,250), dir 00, level 0 -> p_ack one cycle later, slot0 valid at (400,250); after 1 tick, slot0 at (412,262).
REQ-036 Bounce: slot at x=560, xdir=0, level 3 -> after tick x=563 and xdir=1; next tick x=548.
REQ-037 Contention: slots 0-2 full; p_req and e_req both held -> p_ack only, slot3 owner=0. Free slot3 -> e_ack, slot3 owner=1.
REQ-038 Lifetime: launch, then 16 ticks -> valid drops on 16th tick. Simultaneous p_req -> granted into a different free slot, or into this slot only the following cycle.
REQ-039 Saturation/clear: p_req at (100,500) -> loaded as (364,320). Four slots valid, clear asserted with e_req -> all invalid, no e_ack that cycle, e_ack the next cycle.
REQ-040 Async reset mid-grant: rst pulsed between request sample and ack -> no ack, all slot_valid=0 immediately, without waiting for a clock edge.
